// File: rtl/mem_bus_arbiter_pkg.sv
// ============================================================================
// Module  : mem_bus_arbiter_pkg
// Brief   : Shared FSM encodings and master index constants for the arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_bus_arbiter_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_WAIT = 1'b1;

    localparam int MI_IFETCH = 0;
    localparam int MI_DATA   = 1;
    localparam int MI_UART   = 2;
    localparam int MI_SPARE  = 3;

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter_rr_pick.sv
// ============================================================================
// Module  : mem_bus_arbiter_rr_pick
// Brief   : Rotating-priority picker; first pending bit after rr_i wins.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter_rr_pick #(
    parameter int NM = 4,
    parameter int IW = $clog2(NM)
) (
    input  logic [NM-1:0] pend_i,
    input  logic [IW-1:0] rr_i,
    output logic [NM-1:0] gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] j;
    logic          found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 1; k <= NM; k++) begin
            j = IW'((int'(rr_i) + k) % NM);
            if (!found && pend_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
        any_o = found;
    end

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module  : mem_bus_arbiter
// Brief   : Round-robin arbiter sharing one memory port among NM masters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NM      = 4,
    parameter int TIMEOUT = 1023,
    parameter int TO_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NM-1:0]    m_req,
    input  logic [NM-1:0]    m_we,
    input  logic [NM-1:0]    m_w,
    input  logic [NM-1:0]    m_hw,
    input  logic [NM*32-1:0] m_adr,
    input  logic [NM*32-1:0] m_wdata,
    output logic [NM-1:0]    m_done,
    output logic [31:0]      m_rdata,
    output logic             m_err,
    output logic [NM-1:0]    m_ovf,
    output logic             busy,
    output logic             read_req,
    output logic             read_w,
    output logic             read_hw,
    output logic [31:0]      read_adr,
    input  logic             read_valid,
    input  logic [31:0]      read_data,
    output logic             write_req,
    output logic             write_w,
    output logic             write_hw,
    output logic [31:0]      write_adr,
    output logic [31:0]      write_data,
    input  logic             write_finish
);

    localparam int IW = $clog2(NM);

    state_t          state_q, state_d;
    logic [NM-1:0]   pending_q, pending_d;
    logic [NM-1:0]   ovf_q, ovf_d;
    logic [IW-1:0]   rr_q;
    logic [IW-1:0]   gnt_idx_q;
    logic            gnt_we_q;
    logic [TO_W-1:0] cnt_q;

    logic            sl_we_q  [NM];
    logic            sl_w_q   [NM];
    logic            sl_hw_q  [NM];
    logic [31:0]     sl_adr_q [NM];
    logic [31:0]     sl_wdat_q[NM];

    logic            rd_req_q, rd_w_q, rd_hw_q;
    logic [31:0]     rd_adr_q;
    logic            wr_req_q, wr_w_q, wr_hw_q;
    logic [31:0]     wr_adr_q, wr_data_q;
    logic [NM-1:0]   done_q;
    logic            err_q;
    logic [31:0]     rdata_q;

    logic [NM-1:0]   pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            take_en, resp, tmo;
    logic [NM-1:0]   take_vec, cap_vec;

    mem_bus_arbiter_rr_pick #(
        .NM (NM),
        .IW (IW)
    ) u_pick (
        .pend_i (pending_q),
        .rr_i   (rr_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // A slot whose grant is taken this cycle may be refilled without overflow.
    assign take_vec  = pick_gnt & {NM{take_en}};
    assign cap_vec   = m_req & (~pending_q | take_vec);
    assign pending_d = (pending_q & ~take_vec) | cap_vec;
    assign ovf_d     = ovf_q | (m_req & pending_q & ~take_vec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        take_en = 1'b0;
        resp    = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    take_en = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (gnt_we_q ? write_finish : read_valid) begin
                    resp    = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    tmo     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NM; i++) begin
                sl_we_q[i]   <= 1'b0;
                sl_w_q[i]    <= 1'b0;
                sl_hw_q[i]   <= 1'b0;
                sl_adr_q[i]  <= '0;
                sl_wdat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NM; i++) begin
                if (cap_vec[i]) begin
                    sl_we_q[i]   <= m_we[i];
                    sl_w_q[i]    <= m_w[i];
                    sl_hw_q[i]   <= m_hw[i];
                    sl_adr_q[i]  <= m_adr[32*i +: 32];
                    sl_wdat_q[i] <= m_wdata[32*i +: 32];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            ovf_q     <= '0;
            rr_q      <= IW'(NM - 1);
            gnt_idx_q <= '0;
            gnt_we_q  <= 1'b0;
            cnt_q     <= '0;
            rd_req_q  <= 1'b0;
            rd_w_q    <= 1'b0;
            rd_hw_q   <= 1'b0;
            rd_adr_q  <= '0;
            wr_req_q  <= 1'b0;
            wr_w_q    <= 1'b0;
            wr_hw_q   <= 1'b0;
            wr_adr_q  <= '0;
            wr_data_q <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            rd_req_q  <= 1'b0;
            wr_req_q  <= 1'b0;
            done_q    <= '0;
            err_q     <= 1'b0;
            if (take_en) begin
                gnt_idx_q <= pick_idx;
                gnt_we_q  <= sl_we_q[pick_idx];
                rr_q      <= pick_idx;
                cnt_q     <= '0;
                if (sl_we_q[pick_idx]) begin
                    wr_req_q  <= 1'b1;
                    wr_w_q    <= sl_w_q[pick_idx];
                    wr_hw_q   <= sl_hw_q[pick_idx];
                    wr_adr_q  <= sl_adr_q[pick_idx];
                    wr_data_q <= sl_wdat_q[pick_idx];
                end else begin
                    rd_req_q <= 1'b1;
                    rd_w_q   <= sl_w_q[pick_idx];
                    rd_hw_q  <= sl_hw_q[pick_idx];
                    rd_adr_q <= sl_adr_q[pick_idx];
                end
            end
            if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (resp) begin
                done_q <= NM'(1) << gnt_idx_q;
                if (!gnt_we_q) begin
                    rdata_q <= read_data;
                end
            end
            if (tmo) begin
                done_q  <= NM'(1) << gnt_idx_q;
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
        end
    end

    always_comb begin
        busy       = (state_q == ST_WAIT);
        m_done     = done_q;
        m_rdata    = rdata_q;
        m_err      = err_q;
        m_ovf      = ovf_q;
        read_req   = rd_req_q;
        read_w     = rd_w_q;
        read_hw    = rd_hw_q;
        read_adr   = rd_adr_q;
        write_req  = wr_req_q;
        write_w    = wr_w_q;
        write_hw   = wr_hw_q;
        write_adr  = wr_adr_q;
        write_data = wr_data_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module  : tb_mem_bus_arbiter
// Brief   : Directed scoreboard bench for mem_bus_arbiter (NM=4, TIMEOUT=8).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

    localparam int NM = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NM-1:0]    m_req, m_we, m_w, m_hw;
    logic [NM*32-1:0] m_adr, m_wdata;
    logic [NM-1:0]    m_done, m_ovf;
    logic [31:0]      m_rdata;
    logic             m_err, busy;
    logic             read_req, read_w, read_hw, read_valid;
    logic [31:0]      read_adr, read_data;
    logic             write_req, write_w, write_hw, write_finish;
    logic [31:0]      write_adr, write_data;

    typedef struct {
        logic        we;
        logic        w;
        logic        hw;
        logic [31:0] adr;
        logic [31:0] data;
    } req_t;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } cpl_t;

    req_t req_exp[$];
    cpl_t cpl_exp[$];
    req_t me;
    cpl_t mc;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .NM      (NM),
        .TIMEOUT (8),
        .TO_W    (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m_req        (m_req),
        .m_we         (m_we),
        .m_w          (m_w),
        .m_hw         (m_hw),
        .m_adr        (m_adr),
        .m_wdata      (m_wdata),
        .m_done       (m_done),
        .m_rdata      (m_rdata),
        .m_err        (m_err),
        .m_ovf        (m_ovf),
        .busy         (busy),
        .read_req     (read_req),
        .read_w       (read_w),
        .read_hw      (read_hw),
        .read_adr     (read_adr),
        .read_valid   (read_valid),
        .read_data    (read_data),
        .write_req    (write_req),
        .write_w      (write_w),
        .write_hw     (write_hw),
        .write_adr    (write_adr),
        .write_data   (write_data),
        .write_finish (write_finish)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every memory request and every completion is matched in order.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (read_req || write_req) begin
                if (req_exp.size() == 0) begin
                    chk("unexpected_req", {30'b0, write_req, read_req}, 32'h0);
                end else begin
                    me = req_exp.pop_front();
                    chk("req_type", {30'b0, write_req, read_req}, {30'b0, me.we, ~me.we});
                    if (me.we) begin
                        chk("write_w", {31'b0, write_w}, {31'b0, me.w});
                        chk("write_hw", {31'b0, write_hw}, {31'b0, me.hw});
                        chk("write_adr", write_adr, me.adr);
                        chk("write_data", write_data, me.data);
                    end else begin
                        chk("read_w", {31'b0, read_w}, {31'b0, me.w});
                        chk("read_hw", {31'b0, read_hw}, {31'b0, me.hw});
                        chk("read_adr", read_adr, me.adr);
                    end
                end
            end
            if (m_done != '0) begin
                if (cpl_exp.size() == 0) begin
                    chk("unexpected_done", {28'b0, m_done}, 32'h0);
                end else begin
                    mc = cpl_exp.pop_front();
                    chk("done_owner", {28'b0, m_done}, 32'h1 << mc.idx);
                    chk("done_rdata", m_rdata, mc.rdata);
                    chk("done_err", {31'b0, m_err}, {31'b0, mc.err});
                end
            end
        end
    end

    task automatic set_req(input int i, input bit we, input bit w, input bit hw,
                           input logic [31:0] adr, input logic [31:0] wd);
        m_req[i]             = 1'b1;
        m_we[i]              = we;
        m_w[i]               = w;
        m_hw[i]              = hw;
        m_adr[32*i +: 32]    = adr;
        m_wdata[32*i +: 32]  = wd;
    endtask

    task automatic push_req(input bit we, input bit w, input bit hw,
                            input logic [31:0] adr, input logic [31:0] d);
        req_t r;
        r.we = we; r.w = w; r.hw = hw; r.adr = adr; r.data = d;
        req_exp.push_back(r);
    endtask

    task automatic push_cpl(input int idx, input logic [31:0] d, input bit err);
        cpl_t c;
        c.idx = idx; c.rdata = d; c.err = err;
        cpl_exp.push_back(c);
    endtask

    task automatic step();
        @(negedge clk);
        m_req = '0;
    endtask

    task automatic wait_req();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(read_req || write_req) && n < 20);
        chk("req_seen", {31'b0, read_req | write_req}, 32'h1);
    endtask

    // Called at the edge where the request pulse is visible.
    task automatic respond(input int delay, input bit wr, input logic [31:0] d,
                           input int idx, input bit wrong);
        for (int k = 0; k < delay; k++) begin
            if (wrong && k == 0) begin
                if (wr) read_valid = 1'b1; else write_finish = 1'b1;
            end
            @(negedge clk);
            read_valid   = 1'b0;
            write_finish = 1'b0;
            chk("req_pulse_len", {31'b0, read_req | write_req}, 32'h0);
            chk("busy_wait", {31'b0, busy}, 32'h1);
            chk("no_early_done", {28'b0, m_done}, 32'h0);
        end
        if (wr) write_finish = 1'b1;
        else begin
            read_valid = 1'b1;
            read_data  = d;
        end
        @(negedge clk);
        write_finish = 1'b0;
        read_valid   = 1'b0;
        read_data    = 32'hDEAD_BEEF;
        chk("done_latency", {28'b0, m_done}, 32'h1 << idx);
    endtask

    initial begin
        rst_n        = 1'b0;
        m_req        = '0;
        m_we         = '0;
        m_w          = '0;
        m_hw         = '0;
        m_adr        = '0;
        m_wdata      = '0;
        read_valid   = 1'b0;
        read_data    = 32'hDEAD_BEEF;
        write_finish = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_done", {28'b0, m_done}, 32'h0);
        chk("rst_rdata", m_rdata, 32'h0);
        chk("rst_err", {31'b0, m_err}, 32'h0);
        chk("rst_ovf", {28'b0, m_ovf}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_reqs", {30'b0, write_req, read_req}, 32'h0);
        chk("rst_read_adr", read_adr, 32'h0);
        chk("rst_write_adr", write_adr, 32'h0);
        chk("rst_write_data", write_data, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Simultaneous burst after reset: master 0 first, then 1, then 2.
        set_req(0, 0, 1, 0, 32'h10, 32'h0);
        set_req(1, 0, 0, 1, 32'h14, 32'h0);
        set_req(2, 0, 0, 0, 32'h18, 32'h0);
        push_req(0, 1, 0, 32'h10, 32'h0);  push_cpl(0, 32'hA0A0_0000, 0);
        push_req(0, 0, 1, 32'h14, 32'h0);  push_cpl(1, 32'hA0A0_0001, 0);
        push_req(0, 0, 0, 32'h18, 32'h0);  push_cpl(2, 32'hA0A0_0002, 0);
        step();
        wait_req(); respond(1, 0, 32'hA0A0_0000, 0, 0);
        wait_req(); respond(1, 0, 32'hA0A0_0001, 1, 0);
        wait_req(); respond(1, 0, 32'hA0A0_0002, 2, 0);

        // Single read by master 1, response three cycles after the request.
        set_req(1, 0, 1, 0, 32'h0000_0100, 32'h0);
        push_req(0, 1, 0, 32'h0000_0100, 32'h0);
        push_cpl(1, 32'h1234_5678, 0);
        step();
        wait_req(); respond(3, 0, 32'h1234_5678, 1, 0);

        // Pointer now at 1: simultaneous masters 0 and 2 resolve as 2 then 0.
        set_req(0, 0, 1, 0, 32'h20, 32'h0);
        set_req(2, 0, 0, 1, 32'h24, 32'h0);
        push_req(0, 0, 1, 32'h24, 32'h0);  push_cpl(2, 32'hBBBB_0002, 0);
        push_req(0, 1, 0, 32'h20, 32'h0);  push_cpl(0, 32'hBBBB_0000, 0);
        step();
        wait_req(); respond(1, 0, 32'hBBBB_0002, 2, 0);
        wait_req(); respond(2, 0, 32'hBBBB_0000, 0, 0);

        // Write by master 2; a stray read_valid during it must be ignored.
        set_req(2, 1, 1, 0, 32'h200, 32'hCAFE_F00D);
        push_req(1, 1, 0, 32'h200, 32'hCAFE_F00D);
        push_cpl(2, 32'hBBBB_0000, 0);
        step();
        wait_req(); respond(2, 1, 32'h0, 2, 1);

        // Overflow: master 3 requests twice while master 0 is waiting.
        set_req(0, 0, 1, 0, 32'h300, 32'h0);
        push_req(0, 1, 0, 32'h300, 32'h0);  push_cpl(0, 32'h3030_3030, 0);
        push_req(1, 0, 0, 32'h400, 32'h4444); push_cpl(3, 32'h3030_3030, 0);
        step();
        wait_req();
        set_req(3, 1, 0, 0, 32'h400, 32'h4444);
        step();
        set_req(3, 1, 0, 0, 32'h500, 32'h5555);
        step();
        chk("ovf_sticky", {28'b0, m_ovf}, 32'h8);
        respond(0, 0, 32'h3030_3030, 0, 0);
        wait_req(); respond(1, 1, 32'h0, 3, 0);

        // Timeout: no response, completion with error 8 cycles after request.
        set_req(1, 0, 1, 0, 32'h600, 32'h0);
        push_req(0, 1, 0, 32'h600, 32'h0);
        push_cpl(1, 32'h0, 1);
        step();
        wait_req();
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k < 8) chk("tmo_not_yet", {28'b0, m_done}, 32'h0);
        end
        chk("tmo_done", {28'b0, m_done}, 32'h2);
        chk("tmo_err", {31'b0, m_err}, 32'h1);
        read_valid = 1'b1;
        read_data  = 32'h7777_7777;
        @(negedge clk);
        read_valid = 1'b0;
        @(negedge clk);
        chk("late_resp_ignored", {28'b0, m_done}, 32'h0);
        chk("late_rdata_kept", m_rdata, 32'h0);
        chk("idle_after_tmo", {31'b0, busy}, 32'h0);

        // Asynchronous reset in the middle of a WAIT.
        set_req(0, 0, 1, 0, 32'h700, 32'h0);
        push_req(0, 1, 0, 32'h700, 32'h0);
        step();
        wait_req();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'h0);
        chk("arst_read_adr", read_adr, 32'h0);
        chk("arst_ovf", {28'b0, m_ovf}, 32'h0);
        chk("arst_done", {28'b0, m_done}, 32'h0);
        @(negedge clk);
        rst_n      = 1'b1;
        read_valid = 1'b1;
        read_data  = 32'h5A5A_5A5A;
        @(negedge clk);
        read_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_done", {28'b0, m_done}, 32'h0);
        end
        chk("post_rst_busy", {31'b0, busy}, 32'h0);
        chk("req_queue_drained", req_exp.size(), 32'h0);
        chk("cpl_queue_drained", cpl_exp.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
